// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one uart_tx transmitter between N_REQ requesters. Arbitration is
//   round-robin. A granted requester keeps the transmitter until its byte
//   flagged "last" has drained, so packets are never interleaved.
//   Each byte goes through the same sequence: accept (LOCKED), start pulse
//   (START), one blind cycle for the busy-rise latency (GUARD), then wait for
//   the transmitter to go idle (DRAIN).
//
// Parameters
//   N_REQ   : number of requesters (>= 2)
//   WIDTH   : data bits per byte, matches uart_tx WIDTH
//   TIMEOUT : idle LOCKED cycles before a locked grant is revoked
//
// Optional feature (compile-time macro UART_ARB_TIMEOUT_EN)
//   When defined, a granted requester that leaves valid low for TIMEOUT
//   LOCKED cycles loses its grant as if it had sent its last byte.
//   When undefined, no counter exists and the lock is held until last.
//
// Ports
//   clk          : system clock
//   i_reset_n    : asynchronous active-low reset
//   i_req_valid  : per-requester byte valid
//   i_req_data   : per-requester byte, requester k at [k*WIDTH +: WIDTH]
//   i_req_last   : per-requester last-byte-of-packet flag
//   o_req_ready  : per-requester accept (subset of o_grant)
//   o_grant      : one-hot owner of the transmitter, zero when unowned
//   o_tx_data    : byte presented to uart_tx (held until the next accept)
//   o_tx_start   : one-cycle start pulse to uart_tx
//   i_tx_busy    : uart_tx busy
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   i_reset_n,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*WIDTH-1:0] i_req_data,
  input  logic [N_REQ-1:0]       i_req_last,
  output logic [N_REQ-1:0]       o_req_ready,
  output logic [N_REQ-1:0]       o_grant,
  output logic [WIDTH-1:0]       o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_busy
);

  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || TIMEOUT < 1) begin : g_param_check
    $error("uart_tx_arbiter: N_REQ must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOCKED,
    S_START,
    S_GUARD,
    S_DRAIN
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant_idx;
  logic              last_q;

  logic [N_REQ-1:0]  valid_rot;
  logic [IDX_W-1:0]  pick_off;
  logic [IDX_W:0]    pick_sum;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  rr_next;
  logic [WIDTH-1:0]  req_data_arr [N_REQ];
  logic              accept;
  logic              timeout_hit;

  // Rotate the request vector so that bit 0 is the requester at rr_ptr; the
  // lowest set bit of the rotated vector is then the round-robin winner.
  assign valid_rot = N_REQ'({i_req_valid, i_req_valid} >> rr_ptr);

  // NOTE: every variable written in always_comb gets a default assignment
  // first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    pick_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (valid_rot[i]) pick_off = IDX_W'(i);
    end
    pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
    if (pick_sum >= (IDX_W + 1)'(N_REQ)) pick_sum = pick_sum - (IDX_W + 1)'(N_REQ);
    pick_idx = IDX_W'(pick_sum);
  end

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      req_data_arr[k] = i_req_data[k*WIDTH +: WIDTH];
    end
  end

  assign rr_next     = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
  assign accept      = (state == S_LOCKED) && !i_tx_busy && i_req_valid[grant_idx];
  // o_grant is one-hot, so masking it gives the single ready bit.
  assign o_req_ready = accept ? o_grant : '0;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] idle_cnt;

  // Fires in the LOCKED cycle that would be the TIMEOUT-th idle one.
  assign timeout_hit = (state == S_LOCKED) && !i_req_valid[grant_idx] &&
                       (idle_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      idle_cnt <= '0;
    end else if (state == S_IDLE || accept || timeout_hit) begin
      idle_cnt <= '0;
    end else if (state == S_LOCKED && !i_req_valid[grant_idx]) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: state is written with non-blocking assignments so every register
  // in this block sees pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= S_IDLE;
      o_grant    <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      rr_ptr     <= '0;
      grant_idx  <= '0;
      last_q     <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|i_req_valid) begin
            o_grant   <= N_REQ'(1) << pick_idx;
            grant_idx <= pick_idx;
            state     <= S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (accept) begin
            o_tx_data  <= req_data_arr[grant_idx];
            last_q     <= i_req_last[grant_idx];
            o_tx_start <= 1'b1;
            state      <= S_START;
          end else if (timeout_hit) begin
            o_grant <= '0;
            rr_ptr  <= rr_next;
            state   <= S_IDLE;
          end
        end
        S_START: state <= S_GUARD;
        // Busy may not have risen yet, so this cycle never looks at it.
        S_GUARD: state <= S_DRAIN;
        S_DRAIN: begin
          if (!i_tx_busy) begin
            if (last_q) begin
              o_grant <= '0;
              rr_ptr  <= rr_next;
              state   <= S_IDLE;
            end else begin
              state <= S_LOCKED;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter. A transmitter model raises busy
//   one cycle after each start pulse and logs every byte started. Packet order
//   is predicted from per-requester packet queues and a round-robin pointer.
//   Define UART_ARB_TIMEOUT_EN for both files to include the timeout sequence.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N_REQ   = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 8;

  logic                   clk = 1'b0;
  logic                   i_reset_n;
  logic [N_REQ-1:0]       i_req_valid;
  logic [N_REQ*WIDTH-1:0] i_req_data;
  logic [N_REQ-1:0]       i_req_last;
  logic [N_REQ-1:0]       o_req_ready;
  logic [N_REQ-1:0]       o_grant;
  logic [WIDTH-1:0]       o_tx_data;
  logic                   o_tx_start;
  logic                   i_tx_busy;

  uart_tx_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .i_reset_n  (i_reset_n),
    .i_req_valid(i_req_valid),
    .i_req_data (i_req_data),
    .i_req_last (i_req_last),
    .o_req_ready(o_req_ready),
    .o_grant    (o_grant),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .i_tx_busy  (i_tx_busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- transmitter model and start log ----------------
  typedef struct {
    logic [N_REQ-1:0] grant;
    logic [WIDTH-1:0] data;
    int               cyc;
  } start_t;

  start_t start_log[$];
  int     busy_cnt;
  int     busy_len  = 10;
  bit     busy_rand = 1'b0;
  int     cyc_cnt;

  always @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      busy_cnt <= 0;
      cyc_cnt  <= 0;
    end else begin
      cyc_cnt <= cyc_cnt + 1;
      if (o_tx_start) begin
        busy_cnt <= busy_rand ? int'($urandom_range(1, 5)) : busy_len;
        start_log.push_back('{o_grant, o_tx_data, cyc_cnt});
      end else if (busy_cnt != 0) begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  assign i_tx_busy = (busy_cnt != 0);

  // ---------------- invariant monitor ----------------
  int   inv_viol   = 0;
  logic prev_start = 1'b0;

  always @(negedge clk) begin
    #2;
    if (i_reset_n === 1'b1) begin
      if (!$onehot0(o_grant)) begin
        inv_viol++;
        $display("FAIL inv_grant_onehot: got %b, expected one-hot or zero", o_grant);
      end
      if ((o_req_ready & ~o_grant) != '0) begin
        inv_viol++;
        $display("FAIL inv_ready_in_grant: ready %b, grant %b", o_req_ready, o_grant);
      end
      if (o_tx_start && prev_start) begin
        inv_viol++;
        $display("FAIL inv_start_pulse: got two start cycles in a row, expected one");
      end
      if ((o_tx_start || |o_req_ready) && i_tx_busy) begin
        inv_viol++;
        $display("FAIL inv_busy: start %b ready %b while busy, expected 0", o_tx_start, o_req_ready);
      end
    end
    prev_start = o_tx_start;
  end

  // ---------------- requester side ----------------
  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  typedef struct {
    logic [N_REQ-1:0] grant;
    logic [WIDTH-1:0] data;
  } exp_t;

  beat_t pend [N_REQ][$];
  int    start_delay [N_REQ];
  exp_t  exp_q[$];
  int    model_ptr;
  int    log_base;

  task automatic set_req(input int k, input logic v, input logic [WIDTH-1:0] d, input logic l);
    i_req_valid[k]                = v;
    i_req_data[k*WIDTH +: WIDTH]  = d;
    i_req_last[k]                 = l;
  endtask

  task automatic do_reset();
    i_reset_n   = 1'b0;
    i_req_valid = '0;
    i_req_data  = '0;
    i_req_last  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pend[k].delete();
      start_delay[k] = 0;
    end
    model_ptr = 0;
    busy_rand = 1'b0;
    busy_len  = 10;
    repeat (2) @(negedge clk);
    i_reset_n = 1'b1;
  endtask

  // Called at a negedge after set_req; returns #1 past the negedge where
  // ready for requester k is seen, or after the budget runs out.
  task automatic wait_ready(input int k, input string name);
    int n = 0;
    #1;
    while (!o_req_ready[k] && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, o_req_ready[k], 1'b1);
  endtask

  task automatic wait_unowned(input string name, input int max_cycles);
    int n = 0;
    while (o_grant != '0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(name, o_grant, '0);
  endtask

  // Plays out every queued beat; each requester holds valid until accepted,
  // optionally pausing 0..gap_max cycles between bytes of the same packet.
  task automatic run_traffic(input int max_cycles, input int gap_max);
    logic [N_REQ-1:0] rdy = '0;
    int gap [N_REQ];
    int cyc  = 0;
    int left = 0;
    bit work;
    for (int k = 0; k < N_REQ; k++) gap[k] = 0;
    log_base = start_log.size();
    forever begin
      @(negedge clk);
      for (int k = 0; k < N_REQ; k++) begin
        if (rdy[k]) begin
          if (!pend[k][0].last) gap[k] = int'($urandom_range(0, gap_max));
          void'(pend[k].pop_front());
        end
      end
      work = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
        if (start_delay[k] > 0) start_delay[k]--;
        else if (gap[k] > 0) gap[k]--;
        if (pend[k].size() > 0 && start_delay[k] == 0 && gap[k] == 0)
          set_req(k, 1'b1, pend[k][0].data, pend[k][0].last);
        else
          set_req(k, 1'b0, '0, 1'b0);
        if (pend[k].size() > 0) work = 1'b1;
      end
      if (!work || cyc >= max_cycles) break;
      #1 rdy = o_req_ready;
      cyc++;
    end
    i_req_valid = '0;
    for (int k = 0; k < N_REQ; k++) left += pend[k].size();
    check("traffic_left", left, 0);
  endtask

  // Packet-level round-robin: the next packet comes from the first requester
  // at or after the pointer that still has packets; the pointer then moves
  // past it. Packets are sent whole.
  task automatic build_rr_expected();
    int idx [N_REQ];
    int p = model_ptr;
    int w;
    logic [N_REQ-1:0] g;
    exp_q.delete();
    for (int k = 0; k < N_REQ; k++) idx[k] = 0;
    forever begin
      w = -1;
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (idx[(p + i) % N_REQ] < pend[(p + i) % N_REQ].size()) w = (p + i) % N_REQ;
      end
      if (w < 0) break;
      g = '0;
      g[w] = 1'b1;
      forever begin
        exp_q.push_back('{g, pend[w][idx[w]].data});
        idx[w]++;
        if (pend[w][idx[w]-1].last || idx[w] >= pend[w].size()) break;
      end
      p = (w + 1) % N_REQ;
    end
    model_ptr = p;
  endtask

  task automatic compare_log(input string name);
    check({name, "_count"}, start_log.size() - log_base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (log_base + i < start_log.size()) begin
        check($sformatf("%s_grant%0d", name, i), start_log[log_base+i].grant, exp_q[i].grant);
        check($sformatf("%s_data%0d", name, i), start_log[log_base+i].data, exp_q[i].data);
      end
    end
  endtask

  // ---------------- arbitration vector table ----------------
  typedef struct {
    int               prev;   // requester whose 1-byte packet sets the pointer, -1 = none
    logic [N_REQ-1:0] mask;   // i_req_valid presented in IDLE
    logic [N_REQ-1:0] exp;    // expected o_grant one cycle later
  } vec_t;

  initial begin
    vec_t vecs [9];
    int   n;
    int   npk;
    int   len;

    vecs[0] = '{-1, 4'b0001, 4'b0001};
    vecs[1] = '{-1, 4'b1010, 4'b0010};
    vecs[2] = '{ 0, 4'b0001, 4'b0001};
    vecs[3] = '{ 1, 4'b0011, 4'b0001};
    vecs[4] = '{ 2, 4'b1111, 4'b1000};
    vecs[5] = '{ 3, 4'b1110, 4'b0010};
    vecs[6] = '{ 1, 4'b1101, 4'b0100};
    vecs[7] = '{ 3, 4'b0000, 4'b0000};
    vecs[8] = '{ 2, 4'b0110, 4'b0010};

    // Reset values
    do_reset();
    #1;
    check("rst_grant", o_grant, '0);
    check("rst_ready", o_req_ready, '0);
    check("rst_tx_data", o_tx_data, '0);
    check("rst_tx_start", o_tx_start, 1'b0);

    // Reset while DRAIN is waiting on busy
    @(negedge clk);
    set_req(0, 1'b1, 8'h5A, 1'b0);
    wait_ready(0, "t1_accept");
    @(negedge clk);
    set_req(0, 1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);
    check("t1_busy_in_drain", i_tx_busy, 1'b1);
    check("t1_grant_before", o_grant, 4'b0001);
    check("t1_data_before", o_tx_data, 8'h5A);
    set_req(0, 1'b1, 8'h77, 1'b0);
    #3 i_reset_n = 1'b0;
    #1;
    check("t1_async_grant", o_grant, '0);
    check("t1_async_ready", o_req_ready, '0);
    check("t1_async_data", o_tx_data, '0);
    check("t1_async_start", o_tx_start, 1'b0);
    @(negedge clk);
    set_req(0, 1'b0, '0, 1'b0);
    i_reset_n = 1'b1;
    @(negedge clk);
    check("t1_idle_grant", o_grant, '0);
    set_req(1, 1'b1, 8'h11, 1'b1);
    @(negedge clk);
    #1;
    check("t1_rearb_grant", o_grant, 4'b0010);
    check("t1_rearb_ready", o_req_ready, 4'b0010);

    // Round-robin arbitration table
    for (int v = 0; v < 9; v++) begin
      do_reset();
      if (vecs[v].prev >= 0) begin
        pend[vecs[v].prev].push_back('{8'hE0, 1'b1});
        run_traffic(200, 0);
        wait_unowned($sformatf("vec%0d_release", v), 100);
      end
      i_req_valid = vecs[v].mask;
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_grant", v), o_grant, vecs[v].exp);
      check($sformatf("vec%0d_ready", v), o_req_ready, vecs[v].exp);
    end

    // Requester 2 alone, three-byte packet, 10-cycle busy
    do_reset();
    pend[2].push_back('{8'hA1, 1'b0});
    pend[2].push_back('{8'hA2, 1'b0});
    pend[2].push_back('{8'hA3, 1'b1});
    build_rr_expected();
    run_traffic(500, 0);
    wait_unowned("t2_release", 100);
    compare_log("t2");
    for (int i = 1; i < 3; i++) begin
      if (log_base + i < start_log.size())
        check($sformatf("t2_spacing%0d", i),
              (start_log[log_base+i].cyc - start_log[log_base+i-1].cyc) >= 3 + busy_len, 1'b1);
    end

    // Requesters 0, 1, 3 with one-byte packets, then a second round 0 and 3
    do_reset();
    busy_len = 3;
    pend[0].push_back('{8'h10, 1'b1});
    pend[1].push_back('{8'h11, 1'b1});
    pend[3].push_back('{8'h13, 1'b1});
    build_rr_expected();
    run_traffic(500, 0);
    wait_unowned("t3a_release", 100);
    compare_log("t3a");
    pend[0].push_back('{8'h20, 1'b1});
    pend[3].push_back('{8'h23, 1'b1});
    build_rr_expected();
    run_traffic(500, 0);
    wait_unowned("t3b_release", 100);
    compare_log("t3b");

    // Requester 0 arrives while requester 1 is mid-packet
    do_reset();
    pend[1].push_back('{8'hB0, 1'b0});
    pend[1].push_back('{8'hB1, 1'b0});
    pend[1].push_back('{8'hB2, 1'b0});
    pend[1].push_back('{8'hB3, 1'b1});
    pend[0].push_back('{8'hC0, 1'b1});
    start_delay[0] = 20;
    exp_q.delete();
    exp_q.push_back('{4'b0010, 8'hB0});
    exp_q.push_back('{4'b0010, 8'hB1});
    exp_q.push_back('{4'b0010, 8'hB2});
    exp_q.push_back('{4'b0010, 8'hB3});
    exp_q.push_back('{4'b0001, 8'hC0});
    run_traffic(1000, 0);
    wait_unowned("t4_release", 100);
    compare_log("t4");

    // Randomized packet traffic against the round-robin packet model
    for (int r = 0; r < 4; r++) begin
      do_reset();
      busy_rand = 1'b1;
      for (int k = 0; k < N_REQ; k++) begin
        npk = int'($urandom_range(0, 3));
        for (int p = 0; p < npk; p++) begin
          len = int'($urandom_range(1, 4));
          for (int b = 0; b < len; b++)
            pend[k].push_back('{WIDTH'($urandom), (b == len - 1)});
        end
      end
      build_rr_expected();
      run_traffic(5000, 2);
      wait_unowned($sformatf("rand%0d_release", r), 100);
      compare_log($sformatf("rand%0d", r));
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Requester 2 stalls after one non-last byte; requester 3 is pending
    do_reset();
    busy_len = 4;
    @(negedge clk);
    set_req(2, 1'b1, 8'h62, 1'b0);
    set_req(3, 1'b1, 8'h63, 1'b1);
    wait_ready(2, "t6_accept");
    @(negedge clk);
    set_req(2, 1'b0, '0, 1'b0);
    n = 0;
    while (!i_tx_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    while (i_tx_busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("t6_busy_fell", i_tx_busy, 1'b0);
    // One DRAIN cycle sees busy low, then TIMEOUT idle LOCKED cycles.
    n = 0;
    while (o_grant == 4'b0100 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_hold_cycles", n, TIMEOUT + 1);
    check("t6_released", o_grant, '0);
    @(negedge clk);
    check("t6_next_grant", o_grant, 4'b1000);
`endif

    check("invariants", inv_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx transmitter between N_REQ requesters using round-robin arbitration with packet locking. A granted requester keeps the transmitter until it sends a byte flagged last, so its packet is never interleaved with another requester's. The block sits between the command/response sources and the single uart_tx instance. It sequences each byte as follows: accept from the requester, pulse start to the transmitter, then wait for the transmitter to go idle.

Parameters:
N_REQ, 4, number of requesters (>=2)
WIDTH, 8, data bits per byte; matches uart_tx WIDTH
TIMEOUT, 1024, idle cycles before a locked grant is revoked (used only with UART_ARB_TIMEOUT_EN)

Ports:
clk  input  1  system clock; the block uses one clock only
i_reset_n  input  1  reset, asynchronous and active-low
i_req_valid  input  N_REQ  per-requester byte valid
i_req_data  input  N_REQ*WIDTH  per-requester byte; requester k uses bits [k*WIDTH +: WIDTH]
i_req_last  input  N_REQ  per-requester flag marking the final byte of a packet
o_req_ready  output  N_REQ  per-requester accept; at most one bit set
o_grant  output  N_REQ  one-hot owner of the transmitter; all zero when unowned
o_tx_data  output  WIDTH  byte sent to uart_tx
o_tx_start  output  1  one-cycle start pulse to uart_tx
i_tx_busy  input  1  uart_tx busy; rises no later than 1 cycle after o_tx_start

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: o_req_ready=0, o_grant=0, o_tx_data=0, o_tx_start=0, rr pointer=0, state=IDLE.
- Reset mid-operation: all outputs clear immediately, without waiting for a clock edge. A byte in flight is abandoned.
- State IDLE:
  - If no i_req_valid bit is set, stay in IDLE.
  - Otherwise select the first valid index, scanning upward from the rr pointer and wrapping modulo N_REQ.
  - Register the selection into o_grant and go to LOCKED. Arbitration latency is 1 cycle.
- State LOCKED (g = granted index):
  - When i_req_valid[g]=1 and i_tx_busy=0, drive o_req_ready[g]=1 combinationally. The transfer happens in that cycle.
  - Register the byte into o_tx_data and the last flag internally, then go to START.
  - i_req_valid bits of non-granted requesters are ignored.
- State START: o_tx_start=1 for exactly one cycle, then go to GUARD.
- State GUARD: lasts one cycle and ignores i_tx_busy, covering the transmitter's busy-rise latency. Then go to DRAIN.
- State DRAIN: wait for i_tx_busy=0, then:
  - If the stored last flag was 1: clear o_grant, set rr pointer = (g+1) mod N_REQ, go to IDLE.
  - Otherwise go back to LOCKED, keeping the grant.
- Byte throughput: at most one byte per (3 + transmitter busy time) cycles.
- o_tx_data holds its value until the next accepted byte; it is not cleared on release.
- Requester rule: i_req_data and i_req_last must stay stable while valid is high and ready is low. The arbiter never drops valid on a requester's behalf.
- A granted requester that deasserts valid mid-packet keeps its grant indefinitely, unless the optional feature is compiled in.
- Multiple simultaneous requests in IDLE are resolved by rr order only; there is no fixed priority.
- A single-byte packet (last on the first byte) is legal and releases after one byte.
- Invariants: o_grant is one-hot or zero. o_req_ready is a subset of o_grant. o_tx_start is never high in two consecutive cycles.

Optional Feature:
Macro UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter of WIDTH $clog2(TIMEOUT+1) increments every LOCKED cycle in which i_req_valid[g]=0, and clears on each accepted byte.
  - When it reaches TIMEOUT, release the grant as if last had been sent: clear o_grant, advance the rr pointer, go to IDLE.
  - The counter does not run in START, GUARD or DRAIN.
- Not defined: no counter is built, and the lock is held until last.

Test Plan:
1. Reset while in DRAIN -> outputs clear immediately; state is IDLE; o_grant=0.
2. Requester 2 alone sends 3 bytes 0xA1,0xA2,0xA3, last on 0xA3, with a busy model of 10 cycles -> three o_tx_start pulses carrying those bytes in order; o_grant=4'b0100 throughout; o_grant=0 after the final DRAIN.
3. Requesters 0, 1 and 3 all valid with 1-byte packets, pointer=0 -> grants in order 0,1,3; a second round from 0 and 3 starts at 0 after the pointer wraps.
4. Requester 1 is mid-packet (2 of 4 bytes sent) when requester 0 raises valid -> requester 0 is not granted until requester 1's last byte drains; o_req_ready[0] stays 0 until then.
5. Busy model that rises 1 cycle after start -> no second start is issued while busy is high; GUARD prevents an early re-accept.
6. With UART_ARB_TIMEOUT_EN and TIMEOUT=8: requester 2 stops after 1 byte without last -> grant released after exactly 8 idle LOCKED cycles; a pending requester 3 is granted on the next arbitration cycle.
